// File: rtl/bka_pipe_sub.sv
// bka_pipe_sub: two-stage Brent-Kung prefix subtractor (a - b - bin) with valid/ready stall pipeline.
// Stage 1 runs the prefix up-sweep; stage 2 finishes root/down-sweep, folds in cin, forms diff and flags.
module bka_pipe_sub #(
   parameter int N = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         bin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] diff,
   output logic         bout,
   output logic         zero,
   output logic         ovf
);
   localparam int L = $clog2(N);
   logic         s1_valid_q, out_valid_q, s1_load, s2_load;
   logic [N-1:0] g_d, gp_d, g_q, gp_q, p_q, g_t, p_t, cy, diff_d, diff_q;
   logic         cin_q, a_msb_q, b_msb_q, bout_d, zero_d, ovf_d, bout_q, zero_q, ovf_q;
   assign s2_load  = s1_valid_q & (~out_valid_q | out_ready);
   assign in_ready = ~s1_valid_q | s2_load;
   assign s1_load  = in_valid & in_ready;
   assign out_valid = out_valid_q;
   assign diff = diff_q;
   assign bout = bout_q;
   assign zero = zero_q;
   assign ovf  = ovf_q;
   // Up-sweep: node i with (i+1) a multiple of 2^(l+1) absorbs the group ending 2^l below it.
   always_comb begin
      g_d  = a & ~b;
      gp_d = a ^ ~b;
      for (int l = 0; l < L - 1; l++)
         for (int i = (2 << l) - 1; i < N; i += (2 << l)) begin
            g_d[i]  = g_d[i] | (gp_d[i] & g_d[i - (1 << l)]);
            gp_d[i] = gp_d[i] & gp_d[i - (1 << l)];
         end
   end
   always_comb begin
      g_t = g_q;
      p_t = gp_q;
      g_t[N-1] = g_t[N-1] | (p_t[N-1] & g_t[N/2-1]);
      p_t[N-1] = p_t[N-1] & p_t[N/2-1];
      for (int l = L - 2; l >= 0; l--)
         for (int i = 3 * (1 << l) - 1; i < N; i += (2 << l)) begin
            g_t[i] = g_t[i] | (p_t[i] & g_t[i - (1 << l)]);
            p_t[i] = p_t[i] & p_t[i - (1 << l)];
         end
      // Every node now spans [i:0]; cin enters as the carry into bit 0.
      cy     = g_t | (p_t & {N{cin_q}});
      diff_d = p_q ^ {cy[N-2:0], cin_q};
      bout_d = ~cy[N-1];
      zero_d = ~|diff_d;
      ovf_d  = (a_msb_q ^ b_msb_q) & (diff_d[N-1] ^ a_msb_q);
   end
   always_ff @(posedge clk)
      if (s1_load) begin
         g_q     <= g_d;
         gp_q    <= gp_d;
         p_q     <= a ^ ~b;
         cin_q   <= ~bin;
         a_msb_q <= a[N-1];
         b_msb_q <= b[N-1];
      end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         diff_q      <= '0;
         bout_q      <= 1'b0;
         zero_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         s1_valid_q  <= s1_load | (s1_valid_q & ~s2_load);
         out_valid_q <= s2_load | (out_valid_q & ~out_ready);
         if (s2_load) begin
            diff_q <= diff_d;
            bout_q <= bout_d;
            zero_q <= zero_d;
            ovf_q  <= ovf_d;
         end
      end
endmodule

// File: tb/tb_bka_pipe_sub.sv
// tb_bka_pipe_sub: scoreboard bench for bka_pipe_sub (N=64) covering corner vectors,
// random backpressure, back-to-back throughput and reset mid-stream.
module tb_bka_pipe_sub;
   localparam int N = 64;
   logic         clk, rst_n, in_valid, in_ready, bin, out_valid, out_ready, bout, zero, ovf;
   logic [N-1:0] a, b, diff;
   typedef struct {
      logic [N-1:0] diff;
      logic         bout, zero, ovf;
      int           cyc;
   } exp_t;
   exp_t         q[$];
   exp_t         e;
   int           n_chk = 0, n_fail = 0, cyc = 0, n_out = 0, rdy_mode = 0, w = 0;
   logic         lat_chk = 1'b1, prev_stall = 1'b0;
   logic [N+2:0] prev_out;

   bka_pipe_sub #(.N(N)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
      .diff(diff), .bout(bout), .zero(zero), .ovf(ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [N-1:0] av, input logic [N-1:0] bv, input logic bi, input int c);
      exp_t r;
      logic [N:0] full;
      full   = {1'b0, av} - {1'b0, bv} - (N+1)'(bi);
      r.diff = full[N-1:0];
      r.bout = full[N];
      r.zero = (full[N-1:0] == '0);
      r.ovf  = (av[N-1] != bv[N-1]) && (full[N-1] != av[N-1]);
      r.cyc  = c;
      return r;
   endfunction

   always @(posedge clk) begin
      #1;
      out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
   end

   // Inputs settle 1 time unit after posedge, so the negedge view matches what the next edge sees.
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         prev_stall = 1'b0;
      end else begin
         cyc++;
         chk("in_ready", 128'(in_ready), 128'(!(q.size() == 2 && !out_ready)));
         if (prev_stall) begin
            chk("stall_valid", 128'(out_valid), 128'(1));
            chk("stall_data", 128'({diff, bout, zero, ovf}), 128'(prev_out));
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) chk("spurious_out", 128'(1), 128'(0));
            else begin
               e = q.pop_front();
               chk("diff", 128'(diff), 128'(e.diff));
               chk("flags", 128'({bout, zero, ovf}), 128'({e.bout, e.zero, e.ovf}));
               if (lat_chk) chk("latency", 128'(cyc - e.cyc), 128'(2));
               n_out++;
            end
         end
         if (in_valid && in_ready) q.push_back(model(a, b, bin, cyc));
         prev_stall = out_valid && !out_ready;
         prev_out   = {diff, bout, zero, ovf};
      end
   end

   task automatic send(input logic [N-1:0] av, input logic [N-1:0] bv, input logic bi, output int waited);
      in_valid = 1'b1; a = av; b = bv; bin = bi; waited = 0;
      @(negedge clk);
      while (!in_ready && waited < 200) begin
         waited++;
         @(negedge clk);
      end
      if (!in_ready) chk("accept_timeout", 128'(0), 128'(1));
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int k = 0;
      while (q.size() != 0 && k < 500) begin
         k++;
         @(negedge clk);
      end
      chk("drain", 128'(q.size()), 128'(0));
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b1;
      #2;
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_in_ready", 128'(in_ready), 128'(1));
      chk("rst_diff", 128'(diff), 128'(0));
      chk("rst_flags", 128'({bout, zero, ovf}), 128'(0));
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      send(64'd5, 64'd3, 1'b0, w);
      send(64'd0, 64'd1, 1'b0, w);
      send(64'd3, 64'd2, 1'b1, w);
      send(64'h8000_0000_0000_0000, 64'd1, 1'b0, w);
      send(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, w);
      send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, w);
      drain();
      lat_chk = 1'b0; rdy_mode = 1;
      for (int i = 0; i < 10; i++) send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), w);
      drain();
      rdy_mode = 0;
      repeat (2) @(posedge clk);
      #1 lat_chk = 1'b1; n_out = 0;
      for (int i = 0; i < 100; i++) begin
         send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), w);
         chk("b2b_accept", 128'(w), 128'(0));
      end
      drain();
      chk("throughput_count", 128'(n_out), 128'(100));
      rdy_mode = 2;
      repeat (2) @(posedge clk);
      #1;
      send(64'd9, 64'd4, 1'b0, w);
      send(64'd7, 64'd1, 1'b1, w);
      chk("inflight", 128'(q.size()), 128'(2));
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_out_valid", 128'(out_valid), 128'(0));
      chk("rst_mid_in_ready", 128'(in_ready), 128'(1));
      rdy_mode = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1; n_out = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("no_stale_beats", 128'(n_out), 128'(0));
      send(64'h10, 64'h10, 1'b0, w);
      drain();
      chk("post_reset_count", 128'(n_out), 128'(1));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
